// File: rtl/conv_window_sequencer.sv
// 3x3 convolution window sequencer over a 4x4 sample memory: fetches nine
// samples, accumulates weighted products and emits a shifted, saturated result.
module conv_window_sequencer #(
  parameter int unsigned SHIFT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  base_addr,
  input  logic [35:0] kernel,
  input  logic        test_mode,
  output logic [3:0]  address,
  input  logic [15:0] din,
  output logic [7:0]  dout,
  output logic        dout_flag,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  base_q, base_d;
  logic [35:0] kernel_q, kernel_d;
  logic        test_q, test_d;
  logic [23:0] acc_q, acc_d;
  logic [7:0]  dout_q, dout_d;

  logic [3:0]  weights [9];
  logic [3:0]  w_sel;
  logic [3:0]  w_cur;
  logic [19:0] prod;
  logic [23:0] acc_sum;
  logic [23:0] shifted;
  logic [3:0]  offset;

  always_comb begin
    for (int unsigned k = 0; k < 9; k++) begin
      weights[k] = test_q ? 4'd1 : kernel_q[4*k +: 4];
    end
  end

  // din lags address by one cycle, so FETCH index i consumes weight i-1
  // and DRAIN consumes the last weight.
  always_comb begin
    w_sel = 4'd0;
    if (state_q == DRAIN) begin
      w_sel = 4'd8;
    end else if (idx_q != 4'd0) begin
      w_sel = idx_q - 4'd1;
    end
  end

  assign w_cur   = weights[w_sel];
  assign prod    = 20'(din) * 20'(w_cur);
  assign acc_sum = acc_q + 24'(prod);
  assign shifted = acc_sum >> SHIFT;

  always_comb begin
    unique case (idx_q)
      4'd0:    offset = 4'd0;
      4'd1:    offset = 4'd1;
      4'd2:    offset = 4'd2;
      4'd3:    offset = 4'd4;
      4'd4:    offset = 4'd5;
      4'd5:    offset = 4'd6;
      4'd6:    offset = 4'd8;
      4'd7:    offset = 4'd9;
      4'd8:    offset = 4'd10;
      default: offset = 4'd0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    base_d   = base_q;
    kernel_d = kernel_q;
    test_d   = test_q;
    acc_d    = acc_q;
    dout_d   = dout_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = FETCH;
          idx_d    = 4'd0;
          base_d   = base_addr;
          kernel_d = kernel;
          test_d   = test_mode;
          acc_d    = '0;
        end
      end
      FETCH: begin
        if (idx_q != 4'd0) begin
          acc_d = acc_sum;
        end
        if (idx_q == 4'd8) begin
          state_d = DRAIN;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      DRAIN: begin
        acc_d   = acc_sum;
        dout_d  = (|shifted[23:8]) ? 8'hFF : shifted[7:0];
        state_d = OUT;
      end
      OUT: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      base_q   <= '0;
      kernel_q <= '0;
      test_q   <= 1'b0;
      acc_q    <= '0;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      base_q   <= base_d;
      kernel_q <= kernel_d;
      test_q   <= test_d;
      acc_q    <= acc_d;
      dout_q   <= dout_d;
    end
  end

  assign address   = (state_q == FETCH) ? (base_q + offset) : '0;
  assign dout      = dout_q;
  assign dout_flag = (state_q == OUT);
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/conv_window_sequencer.md
CONV_WINDOW_SEQUENCER -- requirements
Module: conv_window_sequencer

Interface
REQ-001 SHALL have parameter SHIFT, default 4: right-shift applied to the accumulator before saturation, range 0..16.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port start  in  1  request one 3x3 window computation; sampled only in IDLE.
REQ-005 SHALL have port base_addr  in  4  top-left address of the window in a 4x4 sample memory (addr = row*4 + col).
REQ-006 SHALL have port kernel  in  36  nine unsigned 4-bit weights; weight i = kernel[4i+3:4i], i = 0..8.
REQ-007 SHALL have port test_mode  in  1  when set, forces all nine weights to 1.
REQ-008 SHALL have port address  out  4  sample memory read address.
REQ-009 SHALL have port din  in  16  unsigned memory read data, valid one cycle after address.
REQ-010 SHALL have port dout  out  8  saturated convolution result.
REQ-011 SHALL have port dout_flag  out  1  one-cycle pulse marking a new dout.
REQ-012 SHALL have port busy  out  1  high while a computation is in progress.

Function
REQ-013 SHALL implement FSM states IDLE, FETCH, DRAIN, OUT with transitions IDLE->FETCH on start, FETCH->DRAIN after 9 cycles, DRAIN->OUT, OUT->IDLE.
REQ-014 SHALL latch base_addr, kernel and test_mode on the IDLE->FETCH edge; later changes to these inputs have no effect on the current computation.
REQ-015 SHALL, in FETCH index i = 0..8, drive address = (base_addr + off[i]) mod 16, with off = 0,1,2,4,5,6,8,9,10; address wrap-around is modulo 16, with no row clipping.
REQ-016 SHALL drive address = 0 in IDLE, DRAIN and OUT.
REQ-017 SHALL clear the 24-bit unsigned accumulator on entry to FETCH, then add din*weight[i-1] in FETCH indices 1..8 and din*weight[8] in DRAIN; each product is 20-bit and no overflow is possible.
REQ-018 SHALL, on the DRAIN->OUT edge, register dout = min(255, final_acc >> SHIFT).
REQ-019 SHALL hold dout unchanged until the next DRAIN->OUT edge.
REQ-020 SHALL assert dout_flag only in the OUT cycle.
REQ-021 SHALL assert busy in FETCH, DRAIN and OUT, and deassert it in IDLE.
REQ-022 SHALL, for start sampled high in IDLE at cycle 0, place FETCH in cycles 1-9, DRAIN in cycle 10 and OUT in cycle 11, giving a fixed latency of 11 cycles to dout_flag.
REQ-023 SHALL ignore start while busy, with no queuing.
REQ-024 SHALL accept start sampled in the cycle following OUT (IDLE), giving a back-to-back throughput of one result per 12 cycles.

Reset
REQ-025 SHALL, with reset high at a clock edge, set state = IDLE, address = 0, dout = 0, dout_flag = 0, busy = 0 and accumulator = 0; reset has priority over start.
REQ-026 SHALL, when reset is asserted mid-operation, abandon the computation: no dout_flag is produced and dout stays 0.

Verification
REQ-027 SHALL verify reset: hold reset 2 cycles with start = 1 -> dout = 0, dout_flag = 0, busy = 0, address = 0.
REQ-028 SHALL verify the basic window: SHIFT = 0, memory din = address, base_addr = 0, test_mode = 1 -> addresses 0,1,2,4,5,6,8,9,10 in cycles 1-9; dout = 45 with dout_flag high in cycle 11 only.
REQ-029 SHALL verify saturation: SHIFT = 0, din = 16'hFFFF, all weights 15 -> dout = 255; with SHIFT = 16, din = 16'h1000, weights 15 -> dout = 8.
REQ-030 SHALL verify wrap-around: base_addr = 11 -> address sequence 11,12,13,15,0,1,3,4,5.
REQ-031 SHALL verify the start rules: start pulses in cycles 3 and 11 are ignored (one dout_flag only); start in cycle 12 is accepted, giving a second dout_flag in cycle 23; kernel changed in cycle 5 does not alter the first result.
REQ-032 SHALL verify reset mid-operation: reset in cycle 5 -> IDLE from cycle 6, busy = 0, no dout_flag, dout = 0; a new start afterwards completes normally.
